seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Upstream neighbour of the seven-segment pattern decoder: a 4-digit multiplexed seven-segment display driver. It captures a 16-bit packed-BCD value on a load strobe and encodes each nibble into a 7-bit segment pattern in the same gfedcba order the decoder consumes. It time-multiplexes the four digits with a programmable refresh divider and offers optional leading-zero blanking. Its segment output is the exact pattern stream the downstream decoder maps back to digits.

## Interface
- REFRESH_DIV, default 50000: clock cycles each digit stays active; legal range 2..2^20.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  single-cycle strobe; captures bcd_in and blank_lz.
- bcd_in  input  16  packed BCD; [3:0] is digit 0 (least significant), [15:12] is digit 3.
- blank_lz  input  1  leading-zero blanking enable, sampled with load.
- seg  output  7  segment pattern, bit6..bit0 = g f e d c b a, active-high.
- dig_en  output  4  one-hot digit enable, active-high; bit i selects digit i.
- err  output  1  high while the held value contains any nibble > 9.

## Operation
- **Holding register.** On clk with load=1, the block captures bcd_in into hold[15:0] and blank_lz into hold_blk. The holding register keeps its value until the next load.
- **err.** err is registered at the same edge as the load: err = any nibble of bcd_in > 9.
- **Refresh counter.** cnt counts 0..REFRESH_DIV-1 and wraps to 0. tick = (cnt == REFRESH_DIV-1).
- **Digit index.** idx[1:0] increments on tick and wraps 3→0. There are no other states.
- **Encoding of the selected nibble n = hold[4*idx+3 : 4*idx]:**
  - 0 → 0111111
  - 1 → 0000110
  - 2 → 1011011
  - 3 → 1001111
  - 4 → 1100110
  - 5 → 1101101
  - 6 → 1111101
  - 7 → 0000111
  - 8 → 1111111
  - 9 → 1100111
  - 10..15 → 1000000 (dash)
- **Leading-zero blanking.** Applies when hold_blk=1. Digit i (i = 3, 2, 1) is blanked (seg=0000000) if nibble i and every higher nibble equal 0. Digit 0 is never blanked. An invalid nibble counts as non-zero.
- **Outputs.** seg and dig_en are registered. Each cycle, seg ← encode(hold, idx, hold_blk) and dig_en ← 1 << idx, both using the current-cycle values of hold and idx.
- **Simultaneous load and tick.** Both take effect at the same edge. The next output cycle uses the new hold and the new idx.
- **Reset priority.** rst overrides load and tick.
- **Mid-scan load.** Reset mid-scan restarts the scan at digit 0. A load mid-scan does not reset cnt or idx.

## Timing
- **Reset values:** cnt=0, idx=0, hold=0, hold_blk=0, err=0, seg=0000000, dig_en=0000 (display dark).
- **First cycle after reset.** The first edge with rst=0 produces dig_en=0001 and seg=0111111 (digit 0 of value 0000).
- **Load latency.** Load at edge N updates hold and err at N. seg reflects the new value at edge N+1, provided the digit being shown is the loaded one.
- **Digit dwell.** Each digit is active for exactly REFRESH_DIV cycles, with no dead cycles between digits. dig_en changes one cycle after the tick edge, because of the registered output.
- **Full scan period:** 4·REFRESH_DIV cycles.
- **dig_en invariant.** dig_en is always exactly one-hot outside reset, and 0000 only during or immediately after reset.

## Test plan
Use REFRESH_DIV=4 throughout.
1. **Reset.** Hold rst=1 for 3 cycles → seg=0000000, dig_en=0000, err=0. Release rst → dig_en=0001, seg=0111111 on the first edge, and dig_en=0010 exactly 4 cycles later.
2. **Scan all digits.** Load bcd_in=16'h1234, blank_lz=0. Over one 16-cycle scan, the bench sees:
   - dig_en=0001 with seg=1100110 (4)
   - dig_en=0010 with seg=1001111 (3)
   - dig_en=0100 with seg=1011011 (2)
   - dig_en=1000 with seg=0000110 (1)
   - Each pair is held for 4 cycles.
3. **Blanking on.** Load 16'h0050, blank_lz=1. Over one scan:
   - digit 0 → 0111111
   - digit 1 → 1101101
   - digits 2 and 3 → 0000000
4. **Blanking edge cases.**
   - Load 16'h0000 with blank_lz=1 → only digit 0 lit (0111111).
   - Load 16'h0000 with blank_lz=0 → all four digits show 0111111.
5. **Invalid nibble.** Load 16'h9A07 → err=1 on the next cycle. Digits read 0000111, 0111111, 1000000, 1100111. A subsequent load of 16'h0007 → err=0.
6. **Load coincident with tick, and reset mid-scan.**
   - Assert load with 16'h8888 on a tick edge → the next cycle shows the new digit with seg=1111111.
   - Assert rst for 1 cycle while idx=2 → outputs zero, then the scan resumes at dig_en=0001.

Source files
------------

// File: rtl/seg_scan_if.sv
// Load/display bundle between a value source (master) and the 4-digit scan driver (slave).
interface seg_scan_if;
    logic        load;
    logic [15:0] bcd_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        err;

    modport master (output load, output bcd_in, output blank_lz,
                    input  seg,  input  dig_en, input  err);
    modport slave  (input  load, input  bcd_in, input  blank_lz,
                    output seg,  output dig_en, output err);
endinterface

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed seven-segment driver: holds a packed-BCD value and scans
// one digit per REFRESH_DIV cycles, with optional leading-zero blanking.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);
    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      hold;
    logic             hold_blk;

    logic             tick_c;
    logic [NIB_W-1:0] nib_c;
    logic             blank_c;
    logic [SEG_W-1:0] seg_c;
    logic             bad_c;

    // gfedcba pattern for one nibble; anything above 9 shows a dash
    function automatic logic [SEG_W-1:0] encode(input logic [NIB_W-1:0] n);
        case (n)
            4'd0:    encode = 7'b0111111;
            4'd1:    encode = 7'b0000110;
            4'd2:    encode = 7'b1011011;
            4'd3:    encode = 7'b1001111;
            4'd4:    encode = 7'b1100110;
            4'd5:    encode = 7'b1101101;
            4'd6:    encode = 7'b1111101;
            4'd7:    encode = 7'b0000111;
            4'd8:    encode = 7'b1111111;
            4'd9:    encode = 7'b1100111;
            default: encode = 7'b1000000;
        endcase
    endfunction

    assign tick_c = (cnt == CNT_W'(REFRESH_DIV - 1));

    // A digit is blank when it and all higher nibbles are zero; digit 0 always shows
    always_comb begin
        nib_c   = 4'(hold >> {idx, 2'b00});
        blank_c = 1'b0;
        case (idx)
            2'd1:    blank_c = (hold[15:4]  == 12'd0);
            2'd2:    blank_c = (hold[15:8]  == 8'd0);
            2'd3:    blank_c = (hold[15:12] == 4'd0);
            default: blank_c = 1'b0;
        endcase
        blank_c = blank_c & hold_blk;
        seg_c   = blank_c ? '0 : encode(nib_c);
    end

    always_comb begin
        bad_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                bad_c = 1'b1;
            end
        end
    end

    // Refresh counter and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (tick_c) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Holding register and error flag, captured on load
    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= 16'd0;
            hold_blk <= 1'b0;
            bus.err  <= 1'b0;
        end else if (bus.load) begin
            hold     <= bus.bcd_in;
            hold_blk <= bus.blank_lz;
            bus.err  <= bad_c;
        end
    end

    // Registered display outputs from the pre-edge hold/idx
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.seg    <= '0;
            bus.dig_en <= 4'd0;
        end else begin
            bus.seg    <= seg_c;
            bus.dig_en <= 4'(1) << idx;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised self-checking bench for seg_scan_driver against a time-based reference model.
module tb_seg_scan_driver;
    localparam int unsigned DIV = 4;

    logic clk;
    logic rst;
    seg_scan_if bus();

    seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          e;          // non-reset edges since the last reset
    logic [15:0] m_hold;
    logic        m_blk;
    logic        m_err;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic [6:0]  pat [16];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [6:0] digit_pattern(input logic [15:0] v, input int i, input logic blk);
        int rest;
        rest = int'(v) / (1 << (4 * i));
        if (blk && i > 0 && rest == 0) return 7'd0;
        return pat[rest % 16];
    endfunction

    function automatic logic any_invalid(input logic [15:0] v);
        int x;
        x = int'(v);
        for (int k = 0; k < 4; k++) begin
            if (x % 16 > 9) return 1'b1;
            x = x / 16;
        end
        return 1'b0;
    endfunction

    // One clock: advance the model with the inputs the DUT samples, then compare
    task automatic cyc();
        int di;
        @(posedge clk);
        if (rst) begin
            e = 0; m_hold = 16'd0; m_blk = 1'b0; m_err = 1'b0;
            exp_seg = 7'd0; exp_dig = 4'd0;
        end else begin
            di      = (e / DIV) % 4;
            exp_seg = digit_pattern(m_hold, di, m_blk);
            exp_dig = 4'(1 << di);
            if (bus.load) begin
                m_hold = bus.bcd_in;
                m_blk  = bus.blank_lz;
                m_err  = any_invalid(bus.bcd_in);
            end
            e++;
        end
        #1;
        chk("seg", 16'(bus.seg), 16'(exp_seg));
        chk("dig_en", 16'(bus.dig_en), 16'(exp_dig));
        chk("err", 16'(bus.err), 16'(m_err));
        if (!rst) chk("onehot", 16'($countones(bus.dig_en)), 16'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic blk);
        bus.load = 1'b1; bus.bcd_in = v; bus.blank_lz = blk;
        cyc();
        bus.load = 1'b0;
    endtask

    // Step until the next edge starts a fresh scan at digit 0
    task automatic align_scan();
        for (int k = 0; k < 4 * DIV && (e % (4 * DIV)) != 0; k++) cyc();
    endtask

    task automatic scan_expect(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                               input logic [6:0] d2, input logic [6:0] d3);
        logic [6:0] want [4];
        want[0] = d0; want[1] = d1; want[2] = d2; want[3] = d3;
        align_scan();
        for (int k = 0; k < 4 * DIV; k++) begin
            cyc();
            chk(tag, 16'(bus.seg), 16'(want[k / DIV]));
        end
    endtask

    initial begin
        pat = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                7'b1111111, 7'b1100111, 7'b1000000, 7'b1000000,
                7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
        e = 0; m_hold = '0; m_blk = 1'b0; m_err = 1'b0; exp_seg = '0; exp_dig = '0;
        rst = 1'b1; bus.load = 1'b0; bus.bcd_in = 16'd0; bus.blank_lz = 1'b0;

        // reset and first scan edges
        for (int k = 0; k < 3; k++) cyc();
        chk("rst_seg", 16'(bus.seg), 16'd0);
        chk("rst_dig", 16'(bus.dig_en), 16'd0);
        rst = 1'b0;
        cyc();
        chk("first_dig", 16'(bus.dig_en), 16'b0001);
        chk("first_seg", 16'(bus.seg), 16'b0111111);
        for (int k = 0; k < 4; k++) cyc();
        chk("second_dig", 16'(bus.dig_en), 16'b0010);

        do_load(16'h1234, 1'b0);
        scan_expect("scan1234", 7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110);
        do_load(16'h0050, 1'b1);
        scan_expect("blank0050", 7'b0111111, 7'b1101101, 7'd0, 7'd0);
        do_load(16'h0000, 1'b1);
        scan_expect("blank0000", 7'b0111111, 7'd0, 7'd0, 7'd0);
        do_load(16'h0000, 1'b0);
        scan_expect("noblank0000", 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);

        do_load(16'h9A07, 1'b0);
        chk("err_set", 16'(bus.err), 16'd1);
        scan_expect("inv9A07", 7'b0000111, 7'b0111111, 7'b1000000, 7'b1100111);
        do_load(16'h0007, 1'b0);
        chk("err_clr", 16'(bus.err), 16'd0);

        // load on the tick edge
        for (int k = 0; k < DIV && (e % DIV) != DIV - 1; k++) cyc();
        do_load(16'h8888, 1'b0);
        cyc();
        chk("tick_load", 16'(bus.seg), 16'b1111111);

        // reset while digit 2 is scanning
        for (int k = 0; k < 4 * DIV && ((e / DIV) % 4) != 2; k++) cyc();
        rst = 1'b1;
        cyc();
        chk("midrst_dig", 16'(bus.dig_en), 16'd0);
        rst = 1'b0;
        cyc();
        chk("midrst_resume", 16'(bus.dig_en), 16'b0001);

        // randomised loads, blanking and occasional resets
        for (int k = 0; k < 600; k++) begin
            logic [15:0] v;
            for (int n = 0; n < 4; n++)
                v[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bus.load     = ($urandom_range(0, 7) == 0);
            bus.bcd_in   = v;
            bus.blank_lz = 1'($urandom_range(0, 1));
            rst          = ($urandom_range(0, 79) == 0);
            cyc();
        end
        bus.load = 1'b0;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
